// File: rtl/pipe_controller_pkg.sv
// pipe_controller_pkg: shared encodings for the MIPS pipeline control block.
// Holds opcode/funct constants, the 4-bit ALU op enum, the 2-bit forward
// select enum and the forwarding-priority helper used for both operands.
package pipe_controller_pkg;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (ir[5:0])
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_LUI   = 4'd11,
    ALU_PASSA = 4'd12
  } aluc_t;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_EXE  = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_LOAD = 2'b11
  } fwd_t;

  // Operand source select; the younger EX result wins over anything in MEM.
  // A load sitting in EX cannot be forwarded, so it falls through (and stalls).
  function automatic fwd_t fwd_sel(input logic [4:0] src,
                                   input logic [4:0] e_des,
                                   input logic       e_wreg,
                                   input logic       e_m2reg,
                                   input logic [4:0] m_des,
                                   input logic       m_wreg,
                                   input logic       m_m2reg);
    fwd_t sel;
    sel = FWD_RF;
    if (e_wreg && !e_m2reg && (e_des != 5'd0) && (e_des == src))
      sel = FWD_EXE;
    else if (m_wreg && !m_m2reg && (m_des != 5'd0) && (m_des == src))
      sel = FWD_MEM;
    else if (m_wreg && m_m2reg && (m_des != 5'd0) && (m_des == src))
      sel = FWD_LOAD;
    return sel;
  endfunction

endpackage

// File: rtl/pipe_controller_alu.sv
// pipe_alu: combinational EX-stage ALU, 32-bit, wrapping arithmetic.
// Ports: aluc (4-bit op), a, b (operands; shifts move b by a[4:0]) -> result.
// Unused op codes return zero.
module pipe_alu
  import pipe_controller_pkg::*;
(
  input  logic [3:0]  aluc,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  aluc_t op;
  assign op = aluc_t'(aluc);

  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_SLT:   result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {31'd0, (a < b)};
      ALU_SLL:   result = b << a[4:0];
      ALU_SRL:   result = b >> a[4:0];
      ALU_SRA:   result = $signed(b) >>> a[4:0];
      ALU_LUI:   result = {b[15:0], 16'd0};
      ALU_PASSA: result = a;
      default:   result = 32'd0;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// pipe_controller: ID decode, hazard/stall, forwarding, branch resolve and
// self-modifying-code detect for a 5-stage MIPS pipe; owns ID/EX controls
// and the EX ALU. Ports: IF/ID ir/id_pc/id_equ, EX/MEM m_*, ID/EX operands
// in; stall/redirect/selects, decoded controls, e_* registers, ex_alu out.
module pipe_controller
  import pipe_controller_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic [31:0] id_pc,
  input  logic        id_equ,
  input  logic [4:0]  m_des,
  input  logic        m_wreg,
  input  logic        m_m2reg,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic [31:0] ex_imm,
  output logic        wpcir,
  output logic        branch,
  output logic        smc,
  output logic        jump,
  output logic        jr,
  output logic        jal,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        wreg,
  output logic        m2reg,
  output logic        wmem,
  output logic        aluimm,
  output logic        shift,
  output logic        regrt,
  output logic        sext,
  output logic [3:0]  aluc,
  output logic [4:0]  des,
  output logic        e_wreg,
  output logic        e_m2reg,
  output logic        e_wmem,
  output logic        e_aluimm,
  output logic        e_shift,
  output logic [3:0]  e_aluc,
  output logic [4:0]  e_des,
  output logic [31:0] ex_alu
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];

  // The shift amount reaches the EX stage through ex_imm[10:6].
  logic unused_shamt;
  assign unused_shamt = ^ir[10:6];

  // Raw decode, before the stall bubble is applied.
  logic  valid, i_alu;
  logic  d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_regrt, d_sext;
  logic  d_jump, d_jr, d_jal, is_beq, is_bne, use_rs, use_rt;
  aluc_t d_aluc;

  always_comb begin
    valid    = 1'b0;
    i_alu    = 1'b0;
    d_wreg   = 1'b0;
    d_m2reg  = 1'b0;
    d_wmem   = 1'b0;
    d_aluimm = 1'b0;
    d_shift  = 1'b0;
    d_regrt  = 1'b0;
    d_sext   = 1'b0;
    d_jump   = 1'b0;
    d_jr     = 1'b0;
    d_jal    = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    d_aluc   = ALU_ADD;
    if (op == OP_RTYPE) begin
      valid  = 1'b1;
      d_wreg = 1'b1;
      use_rs = 1'b1;
      use_rt = 1'b1;
      case (funct)
        F_ADD, F_ADDU: d_aluc = ALU_ADD;
        F_SUB, F_SUBU: d_aluc = ALU_SUB;
        F_AND:  d_aluc = ALU_AND;
        F_OR:   d_aluc = ALU_OR;
        F_XOR:  d_aluc = ALU_XOR;
        F_NOR:  d_aluc = ALU_NOR;
        F_SLT:  d_aluc = ALU_SLT;
        F_SLTU: d_aluc = ALU_SLTU;
        F_SLL:  begin d_aluc = ALU_SLL; d_shift = 1'b1; use_rs = 1'b0; end
        F_SRL:  begin d_aluc = ALU_SRL; d_shift = 1'b1; use_rs = 1'b0; end
        F_SRA:  begin d_aluc = ALU_SRA; d_shift = 1'b1; use_rs = 1'b0; end
        F_JR:   begin d_jr = 1'b1; d_wreg = 1'b0; end
        default: begin
          valid  = 1'b0;
          d_wreg = 1'b0;
          use_rs = 1'b0;
          use_rt = 1'b0;
        end
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_ADDIU: begin i_alu = 1'b1; d_aluc = ALU_ADD; end
        OP_SLTI:  begin i_alu = 1'b1; d_aluc = ALU_SLT; end
        OP_SLTIU: begin i_alu = 1'b1; d_aluc = ALU_SLTU; end
        OP_ANDI:  begin i_alu = 1'b1; d_aluc = ALU_AND; d_sext = 1'b1; end
        OP_ORI:   begin i_alu = 1'b1; d_aluc = ALU_OR;  d_sext = 1'b1; end
        OP_XORI:  begin i_alu = 1'b1; d_aluc = ALU_XOR; d_sext = 1'b1; end
        OP_LUI:   begin i_alu = 1'b1; d_aluc = ALU_LUI; end
        OP_LW: begin
          valid = 1'b1; d_wreg = 1'b1; d_m2reg = 1'b1;
          d_aluimm = 1'b1; d_regrt = 1'b1; use_rs = 1'b1;
        end
        OP_SW: begin
          valid = 1'b1; d_wmem = 1'b1; d_aluimm = 1'b1;
          use_rs = 1'b1; use_rt = 1'b1;
        end
        OP_BEQ: begin valid = 1'b1; is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
        OP_BNE: begin valid = 1'b1; is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
        OP_J:   begin valid = 1'b1; d_jump = 1'b1; end
        // jal links PC+4, which the datapath presents on the A operand.
        OP_JAL: begin
          valid = 1'b1; d_jump = 1'b1; d_jal = 1'b1;
          d_wreg = 1'b1; d_aluc = ALU_PASSA;
        end
        default: ;
      endcase
      if (i_alu) begin
        valid    = 1'b1;
        d_wreg   = 1'b1;
        d_aluimm = 1'b1;
        d_regrt  = 1'b1;
        use_rs   = (op != OP_LUI);
      end
    end
  end

  // Hazards: a load in EX whose result is needed now, or a store in EX that
  // hits the word currently held in IF/ID (flushed slots are all-ones).
  logic load_use;
  assign load_use = e_wreg && e_m2reg && (e_des != 5'd0) &&
                    ((use_rs && (e_des == rs)) || (use_rt && (e_des == rt)));
  assign smc   = e_wmem && (ex_alu[31:2] == id_pc[31:2]) && (id_pc != 32'hFFFF_FFFF);
  assign wpcir = load_use || smc;

  assign fwda = fwd_sel(rs, e_des, e_wreg, e_m2reg, m_des, m_wreg, m_m2reg);
  assign fwdb = fwd_sel(rt, e_des, e_wreg, e_m2reg, m_des, m_wreg, m_m2reg);

  // A stalled ID instruction becomes a bubble: no state-changing controls.
  assign wreg   = d_wreg  && !wpcir;
  assign m2reg  = d_m2reg && !wpcir;
  assign wmem   = d_wmem  && !wpcir;
  assign aluimm = d_aluimm;
  assign shift  = d_shift;
  assign regrt  = d_regrt;
  assign sext   = d_sext;
  assign aluc   = d_aluc;
  assign jump   = d_jump;
  assign jr     = d_jr;
  assign jal    = d_jal;
  assign des    = !valid ? 5'd0 : (d_jal ? 5'd31 : (d_regrt ? rt : rd));

  assign branch = !wpcir && ((is_beq && id_equ) || (is_bne && !id_equ) ||
                             d_jump || d_jr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_wreg   <= 1'b0;
      e_m2reg  <= 1'b0;
      e_wmem   <= 1'b0;
      e_aluimm <= 1'b0;
      e_shift  <= 1'b0;
      e_aluc   <= 4'd0;
      e_des    <= 5'd0;
    end else begin
      e_wreg   <= wreg;
      e_m2reg  <= m2reg;
      e_wmem   <= wmem;
      e_aluimm <= aluimm;
      e_shift  <= shift;
      e_aluc   <= aluc;
      e_des    <= des;
    end
  end

  logic [31:0] alu_a, alu_b;
  assign alu_a = e_shift ? {27'd0, ex_imm[10:6]} : ex_a;
  assign alu_b = e_aluimm ? ex_imm : ex_b;

  pipe_alu u_alu (
    .aluc   (e_aluc),
    .a      (alu_a),
    .b      (alu_b),
    .result (ex_alu)
  );

endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: directed self-checking bench for pipe_controller.
module tb_pipe_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ir, id_pc, ex_a, ex_b, ex_imm;
  logic        id_equ, m_wreg, m_m2reg;
  logic [4:0]  m_des;
  logic        wpcir, branch, smc, jump, jr, jal;
  logic [1:0]  fwda, fwdb;
  logic        wreg, m2reg, wmem, aluimm, shift, regrt, sext;
  logic [3:0]  aluc, e_aluc;
  logic [4:0]  des, e_des;
  logic        e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift;
  logic [31:0] ex_alu;

  int total = 0;
  int bad   = 0;

  pipe_controller dut (
    .clock(clock), .reset(reset), .ir(ir), .id_pc(id_pc), .id_equ(id_equ),
    .m_des(m_des), .m_wreg(m_wreg), .m_m2reg(m_m2reg),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .wpcir(wpcir), .branch(branch), .smc(smc), .jump(jump), .jr(jr), .jal(jal),
    .fwda(fwda), .fwdb(fwdb), .wreg(wreg), .m2reg(m2reg), .wmem(wmem),
    .aluimm(aluimm), .shift(shift), .regrt(regrt), .sext(sext),
    .aluc(aluc), .des(des),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_aluimm(e_aluimm),
    .e_shift(e_shift), .e_aluc(e_aluc), .e_des(e_des), .ex_alu(ex_alu)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] s,
                                        input logic [4:0] t, input logic [4:0] d,
                                        input logic [4:0] sa);
    return {6'b000000, s, t, d, sa, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] opc, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {opc, s, t, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; ir = 32'd0; id_pc = 32'h400; id_equ = 1'b0;
    m_des = 5'd0; m_wreg = 1'b0; m_m2reg = 1'b0;
    ex_a = 32'd0; ex_b = 32'd0; ex_imm = 32'd0;
    #1;
    check("rst_e_wreg", e_wreg, 0);
    check("rst_e_des", e_des, 0);
    tick();
    reset = 1'b0;

    // Load some state, then assert reset mid-cycle.
    ir = r_ins(6'b100000, 5'd1, 5'd2, 5'd7, 5'd0);        // add $7,$1,$2
    tick();
    check("add7_e_wreg", e_wreg, 1);
    check("add7_e_des", e_des, 7);
    ir = i_ins(6'b101011, 5'd1, 5'd2, 16'h1800);          // sw (rd field = 3)
    tick();
    check("sw_e_wmem", e_wmem, 1);
    check("sw_e_des", e_des, 3);
    #3 reset = 1'b1;
    #1;
    check("midrst_e_wreg", e_wreg, 0);
    check("midrst_e_wmem", e_wmem, 0);
    check("midrst_e_des", e_des, 0);
    #1 reset = 1'b0;
    ir = r_ins(6'b100000, 5'd1, 5'd2, 5'd3, 5'd0);        // add $3,$1,$2
    #1;
    check("add3_des", des, 3);
    check("add3_wreg", wreg, 1);
    tick();
    check("add3_e_wreg", e_wreg, 1);
    check("add3_e_aluc", e_aluc, 0);
    check("add3_e_des", e_des, 3);

    // Forwarding
    ir = r_ins(6'b100000, 5'd1, 5'd2, 5'd5, 5'd0);        // add $5,$1,$2
    tick();
    ir = r_ins(6'b100010, 5'd5, 5'd5, 5'd6, 5'd0);        // sub $6,$5,$5
    #1;
    check("fwd_ex_a", fwda, 2'b01);
    check("fwd_ex_b", fwdb, 2'b01);
    check("sub_aluc", aluc, 1);
    check("fwd_ex_wpcir", wpcir, 0);
    tick();                                               // EX now writes $6
    m_des = 5'd5; m_wreg = 1'b1; m_m2reg = 1'b1;
    #1;
    check("fwd_ld_a", fwda, 2'b11);
    check("fwd_ld_b", fwdb, 2'b11);
    m_m2reg = 1'b0;
    #1;
    check("fwd_mem_a", fwda, 2'b10);
    check("fwd_mem_b", fwdb, 2'b10);
    ir = r_ins(6'b100000, 5'd6, 5'd5, 5'd8, 5'd0);        // add $8,$6,$5
    #1;
    check("fwd_prio_a", fwda, 2'b01);
    check("fwd_prio_b", fwdb, 2'b10);
    m_des = 5'd0; m_wreg = 1'b0;

    // Load-use stall
    ir = i_ins(6'b100011, 5'd1, 5'd4, 16'h0000);          // lw $4,0($1)
    tick();
    check("lw_e_m2reg", e_m2reg, 1);
    check("lw_e_des", e_des, 4);
    ir = i_ins(6'b000100, 5'd4, 5'd0, 16'h0003);          // beq $4,$0
    id_equ = 1'b1;
    #1;
    check("lu_beq_wpcir", wpcir, 1);
    check("lu_beq_branch", branch, 0);
    ir = r_ins(6'b100000, 5'd0, 5'd4, 5'd8, 5'd0);        // add $8,$0,$4
    #1;
    check("lu_rt_wpcir", wpcir, 1);
    check("lu_rt_wreg", wreg, 0);
    tick();
    check("bubble_e_wreg", e_wreg, 0);
    check("bubble_e_wmem", e_wmem, 0);
    check("bubble_e_m2reg", e_m2reg, 0);

    // Branches and jumps (EX holds a bubble)
    id_equ = 1'b0;
    ir = i_ins(6'b000100, 5'd1, 5'd2, 16'h0003);          // beq, not equal
    #1;
    check("beq_ne_branch", branch, 0);
    ir = i_ins(6'b000101, 5'd1, 5'd2, 16'h0003);          // bne, not equal
    #1;
    check("bne_ne_branch", branch, 1);
    ir = {6'b000011, 26'h0000040};                        // jal
    #1;
    check("jal_branch", branch, 1);
    check("jal_jal", jal, 1);
    check("jal_des", des, 31);
    check("jal_aluc", aluc, 12);
    check("jal_wreg", wreg, 1);
    ir = r_ins(6'b001000, 5'd31, 5'd0, 5'd0, 5'd0);       // jr $31
    #1;
    check("jr_jr", jr, 1);
    check("jr_branch", branch, 1);
    check("jr_wreg", wreg, 0);
    ir = 32'hFC00_0000;                                   // undefined opcode
    #1;
    check("nop_wreg", wreg, 0);
    check("nop_des", des, 0);
    check("nop_branch", branch, 0);
    ir = i_ins(6'b001100, 5'd1, 5'd2, 16'h00FF);          // andi
    #1;
    check("andi_sext", sext, 1);
    check("andi_regrt", regrt, 1);
    check("andi_des", des, 2);

    // Self-modifying code
    ir = i_ins(6'b101011, 5'd1, 5'd2, 16'h0000);          // sw $2,0($1)
    tick();
    ex_a = 32'h100; ex_imm = 32'h4;
    id_pc = 32'h104;
    #1;
    check("smc_ex_alu", ex_alu, 32'h104);
    check("smc_hit", smc, 1);
    check("smc_wpcir", wpcir, 1);
    check("smc_wmem_bubble", wmem, 0);
    id_pc = 32'h107;
    #1;
    check("smc_same_word", smc, 1);
    id_pc = 32'h108;
    #1;
    check("smc_next_word", smc, 0);
    id_pc = 32'hFFFF_FFFF;
    #1;
    check("smc_flushed", smc, 0);
    check("smc_flushed_wpcir", wpcir, 0);
    id_pc = 32'h400;

    // ALU
    ir = r_ins(6'b000011, 5'd0, 5'd2, 5'd3, 5'd4);        // sra $3,$2,4
    tick();
    ex_imm = 32'h100; ex_a = 32'h8000_0000; ex_b = 32'h1;
    #1;
    check("sra_small", ex_alu, 32'h0);
    ex_b = 32'h8000_0000;
    #1;
    check("sra_neg", ex_alu, 32'hF800_0000);
    ir = r_ins(6'b101011, 5'd1, 5'd2, 5'd3, 5'd0);        // sltu
    tick();
    ex_a = 32'h1; ex_b = 32'hFFFF_FFFF;
    #1;
    check("sltu", ex_alu, 32'h1);
    ir = r_ins(6'b101010, 5'd1, 5'd2, 5'd3, 5'd0);        // slt
    tick();
    #1;
    check("slt_aluc", e_aluc, 6);
    check("slt", ex_alu, 32'h0);
    ir = i_ins(6'b001111, 5'd0, 5'd3, 16'h1234);          // lui $3,0x1234
    tick();
    ex_imm = 32'h0000_1234;
    #1;
    check("lui", ex_alu, 32'h1234_0000);
    ir = r_ins(6'b100111, 5'd1, 5'd2, 5'd3, 5'd0);        // nor
    tick();
    ex_a = 32'h0F0F_0000; ex_b = 32'h0000_00F0;
    #1;
    check("nor", ex_alu, 32'hF0F0_FF0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
